// File: rtl/cube_calc_if.sv
// -----------------------------------------------------------------------------
// cube_calc_if
//   Start/busy/done handshake bundle for the sequential cuber.
//
//   Signals
//     start       master -> slave  request, honoured only while the unit is idle
//     number_in   master -> slave  unsigned operand, latched on the accepting edge
//     busy        slave  -> master operation in progress
//     done        slave  -> master one-cycle pulse, number_out just updated
//     number_out  slave  -> master unsigned cube, held until the next completion
// -----------------------------------------------------------------------------
interface cube_calc_if #(
  parameter int IN_W = 10
);
  logic              start;
  logic [IN_W-1:0]   number_in;
  logic              busy;
  logic              done;
  logic [3*IN_W-1:0] number_out;

  modport master (
    output start,
    output number_in,
    input  busy,
    input  done,
    input  number_out
  );

  modport slave (
    input  start,
    input  number_in,
    output busy,
    output done,
    output number_out
  );
endinterface

// File: rtl/cube_calc.sv
// -----------------------------------------------------------------------------
// cube_calc
//   Sequential unsigned cuber: number_out = number_in^3, computed with a
//   shift-add multiplier that consumes one operand bit per clock.  The first
//   IN_W cycles form x*x, the next IN_W cycles form (x*x)*x.  Latency is
//   data-independent: done pulses in the cycle after the 2*IN_W-th edge
//   following acceptance.  One operation at a time; requests arriving while
//   busy are dropped.
//
//   Ports
//     clk     rising-edge clock
//     reset   asynchronous, active-high; returns every register to zero/IDLE
//     bus     cube_calc_if.slave: start, number_in, busy, done, number_out
//
//   Parameters
//     IN_W    operand width (>= 2); result is exactly 3*IN_W bits wide
// -----------------------------------------------------------------------------
module cube_calc #(
  parameter int IN_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  cube_calc_if.slave  bus
);

  localparam int SQ_W  = 2 * IN_W;
  localparam int ACC_W = 3 * IN_W;
  localparam int CNT_W = $clog2(IN_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CU   = 2'd2
  } state_t;

  state_t             state;
  logic [IN_W-1:0]    x;        // latched operand, also the multiplier in both passes
  logic [SQ_W-1:0]    sq;       // x*x, multiplicand for the second pass
  logic [ACC_W-1:0]   acc;      // running shift-add sum
  logic [CNT_W-1:0]   cnt;      // multiplier bit currently being consumed
  logic               busy_r;
  logic               done_r;
  logic [ACC_W-1:0]   result_r;

  logic               last_bit;
  logic [ACC_W-1:0]   mcand;
  logic [ACC_W-1:0]   term;
  logic [ACC_W-1:0]   sum;

  // One partial product of the shift-add multiplier: mcand shifted to the
  // weight of multiplier bit idx, or zero when that bit is clear.  The result
  // is kept at full accumulator width so no bits are lost in either pass.
  function automatic logic [ACC_W-1:0] partial_product(
    input logic [IN_W-1:0]  mplier,
    input logic [CNT_W-1:0] idx,
    input logic [ACC_W-1:0] mc
  );
    logic [ACC_W-1:0] pp;
    pp = '0;
    if (mplier[idx]) begin
      pp = mc << idx;
    end
    return pp;
  endfunction

  always_comb begin
    last_bit = (cnt == CNT_W'(IN_W - 1));
    // The same adder serves both passes; only the multiplicand changes.
    mcand    = (state == CU) ? ACC_W'(sq) : ACC_W'(x);
    term     = partial_product(x, cnt, mcand);
    sum      = acc + term;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      x        <= '0;
      sq       <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        // ---- idle: wait for a request, latch the operand ----
        IDLE: begin
          if (bus.start) begin
            x      <= bus.number_in;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SQ;
          end
        end

        // ---- first pass: acc = x * x ----
        SQ: begin
          if (last_bit) begin
            // The final partial product is folded in directly so the square
            // is ready on the same edge that starts the second pass.
            sq    <= sum[SQ_W-1:0];
            acc   <= '0;
            cnt   <= '0;
            state <= CU;
          end else begin
            acc <= sum;
            cnt <= cnt + 1'b1;
          end
        end

        // ---- second pass: acc = sq * x, publish on the last bit ----
        CU: begin
          if (last_bit) begin
            result_r <= sum;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            acc <= sum;
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          acc    <= '0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.number_out = result_r;

  // busy drops on the completion edge, so the two flags never overlap.
  a_done_busy_exclusive: assert property (
    @(posedge clk) disable iff (reset) !(done_r && busy_r)
  );

  // busy is a direct image of "not idle".
  a_busy_tracks_state: assert property (
    @(posedge clk) disable iff (reset) (busy_r == (state != IDLE))
  );

endmodule

// File: tb/tb_cube_calc.sv
// -----------------------------------------------------------------------------
// tb_cube_calc
//   Self-checking bench for cube_calc (IN_W = 10).  Every accepted request
//   pushes its expected cube and accept cycle onto a scoreboard; every done
//   pulse pops one entry and checks value and latency.  A table of operands
//   drives the main cases; hand-written sequences cover the busy-ignore,
//   mid-operation reset and held-start corner cases.
// -----------------------------------------------------------------------------
module tb_cube_calc;

  localparam int IN_W  = 10;
  localparam int OUT_W = 3 * IN_W;
  localparam int LAT   = 2 * IN_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cube_calc_if #(.IN_W(IN_W)) bus ();

  cube_calc #(.IN_W(IN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [OUT_W-1:0] exp;
    int               acc_cyc;
  } sb_t;

  typedef struct {
    logic [IN_W-1:0]  din;
    logic [OUT_W-1:0] dout;
  } vec_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  ndone  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [OUT_W-1:0] cube_model(input logic [IN_W-1:0] v);
    logic [63:0] t;
    t = 64'(v);
    return OUT_W'(t * t * t);
  endfunction

  // Advance one clock; sample 1 time unit after the edge.
  task automatic tick();
    logic            will_acc;
    logic [IN_W-1:0] v;
    sb_t             e;
    will_acc = bus.start && !bus.busy && !reset;
    v        = bus.number_in;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.done === 1'b1) begin
      ndone++;
      check("done_busy_excl", 64'(bus.busy), 64'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done at cycle %0d, expected no pending op", cyc);
      end else begin
        e = sbq.pop_front();
        check("result", 64'(bus.number_out), 64'(e.exp));
        check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
      end
    end
    if (will_acc) begin
      sbq.push_back('{exp: cube_model(v), acc_cyc: cyc});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending ops after %0d cycles, expected 0", sbq.size(), budget);
      sbq.delete();
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [OUT_W-1:0] prev_out;
    int               prev_done;
    int               dones_before;

    vecs[0] = '{din: 10'd2,    dout: 30'd8};
    vecs[1] = '{din: 10'd3,    dout: 30'd27};
    vecs[2] = '{din: 10'd10,   dout: 30'd1000};
    vecs[3] = '{din: 10'd0,    dout: 30'd0};
    vecs[4] = '{din: 10'd1023, dout: 30'd1070599167};
    vecs[5] = '{din: 10'd1,    dout: 30'd1};
    vecs[6] = '{din: 10'd7,    dout: 30'd343};

    // ---- reset state ----
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.number_in = '0;
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_out",  64'(bus.number_out), 64'd0);
    reset = 1'b0;
    tick();

    // ---- table-driven single operations ----
    prev_out = '0;
    for (int i = 0; i < 7; i++) begin
      bus.start     = 1'b1;
      bus.number_in = vecs[i].din;
      tick();
      bus.start     = 1'b0;
      bus.number_in = ~vecs[i].din;
      check("busy_after_accept", 64'(bus.busy), 64'd1);
      check("out_held", 64'(bus.number_out), 64'(prev_out));
      wait_idle(LAT + 10);
      check("table_out", 64'(bus.number_out), 64'(vecs[i].dout));
      tick();
      check("done_one_cycle", 64'(bus.done), 64'd0);
      prev_out = vecs[i].dout;
    end

    // ---- start while busy and operand change are ignored ----
    dones_before  = ndone;
    bus.start     = 1'b1;
    bus.number_in = 10'd5;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.start     = 1'b1;
    bus.number_in = 10'd7;
    tick();
    bus.start     = 1'b0;
    bus.number_in = 10'd99;
    wait_idle(LAT + 10);
    for (int i = 0; i < 25; i++) tick();
    check("busy_ignore_out", 64'(bus.number_out), 64'd125);
    check("busy_ignore_ndone", 64'(ndone - dones_before), 64'd1);

    // ---- reset mid-operation aborts with no done ----
    bus.start     = 1'b1;
    bus.number_in = 10'd9;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_out",  64'(bus.number_out), 64'd0);
    sbq.delete();
    dones_before = ndone;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) tick();
    check("abort_no_done", 64'(ndone - dones_before), 64'd0);
    check("abort_out_after", 64'(bus.number_out), 64'd0);

    // ---- start held high: back-to-back operations ----
    dones_before  = ndone;
    prev_done     = -1;
    bus.start     = 1'b1;
    bus.number_in = 10'd4;
    for (int i = 0; i < 3 * (LAT + 1) + 1; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        check("held_out", 64'(bus.number_out), 64'd64);
        if (prev_done >= 0) check("held_period", 64'(cyc - prev_done), 64'(LAT + 1));
        prev_done = cyc;
      end
    end
    bus.start = 1'b0;
    wait_idle(LAT + 10);
    check("held_ndone", 64'(ndone - dones_before), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $fatal(1, "global timeout");
  end

endmodule
